mat2_sm_mul: RTL and testbench
==============================

MAT2_SM_MUL -- requirements
Module: mat2_sm_mul

Interface
REQ-001 Parameter WIDTH, default 16, magnitude width of every operand and result.
REQ-002 Parameter FRAC, default 8, fractional bits (Q8.8 at defaults).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; level-sensitive, sampled only while ready=1.
REQ-006 ready  output  1  high = idle and able to accept start.
REQ-007 done  output  1  one-cycle pulse when a new result is written to the outputs.
REQ-008 aIn, bIn, cIn, dIn  input  WIDTH each  magnitudes of matrix X = [a b; c d].
REQ-009 aIn_sign, bIn_sign, cIn_sign, dIn_sign  input  1 each  X signs (1 = negative).
REQ-010 eIn, fIn, gIn, hIn  input  WIDTH each  magnitudes of matrix Y = [e f; g h].
REQ-011 eIn_sign, fIn_sign, gIn_sign, hIn_sign  input  1 each  Y signs.
REQ-012 aOut, bOut, cOut, dOut  output  WIDTH each  result magnitudes of P = X*Y.
REQ-013 aOut_sign, bOut_sign, cOut_sign, dOut_sign  output  1 each  result signs.
REQ-014 ovf  output  1  at least one element of the last result saturated.

Function
REQ-015 Computes P = X*Y: Pa=a*e+b*g, Pb=a*f+b*h, Pc=c*e+d*g, Pd=c*f+d*h; all values sign-magnitude fixed point, FRAC fractional bits.
REQ-016 Exactly one WIDTHxWIDTH unsigned multiplier; the 8 products are computed sequentially, one per cycle, in order a*e, b*g, a*f, b*h, c*e, d*g, c*f, d*h.
REQ-017 FSM states: IDLE, ACCUM, FINISH; ready=1 only in IDLE.
REQ-018 IDLE: on an edge with start=1, all 16 operand inputs are captured, k cleared to 0, state -> ACCUM; otherwise the state remains IDLE.
REQ-019 ACCUM: each edge adds the signed product k (sign = XOR of operand signs) to that element's accumulator and increments k; after k=7 the state moves to FINISH (8 cycles).
REQ-020 Accumulators: two's complement, 2*WIDTH+2 bits, cleared at capture; no overflow possible.
REQ-021 FINISH: per element, mag = |acc|, rounded = (mag + 2^(FRAC-1)) >> FRAC (half rounds away from zero); if rounded > 2^WIDTH-1, output is 2^WIDTH-1 and ovf is set.
REQ-022 Result sign = 1 only if acc < 0 and the output magnitude is nonzero; negative zero is never produced.
REQ-023 Operand with magnitude 0 and sign 1 is treated as zero.
REQ-024 The FINISH edge writes all four outputs, signs and ovf together, sets done=1 for the next cycle and sets the state to IDLE.
REQ-025 Latency: start accepted at edge T0 -> outputs valid and done=1 after edge T0+9; ready=0 after edges T0..T0+8 and ready=1 after edge T0+9.
REQ-026 start while ready=0 is ignored; input changes after capture do not affect the running operation.
REQ-027 start held high: the next operation is accepted at edge T0+10 (back-to-back; throughput one result per 10 cycles).
REQ-028 Outputs and ovf hold their last value until the next FINISH; ovf reflects only the most recent result.

Reset
REQ-029 rst_n=0 immediately forces: state=IDLE, ready=1, done=0, ovf=0, all magnitudes and signs 0, accumulators and k cleared.
REQ-030 Reset asserted mid-operation aborts the operation; no done pulse follows; after release the block accepts start on the first edge.

Verification
REQ-031 Identity check: X=[0x0200 0x0200; 0x0100 0x0000], Y=[0x0000 0x0100; 0x0080 -0x0100] -> P=[0x0100 0x0000; 0x0000 0x0100], all signs 0, ovf=0, done 9 edges after capture.
REQ-032 Saturation: a=b=0x7F00, e=g=0x7F00, all other operands 0 -> aOut=0xFFFF, aOut_sign=0, ovf=1; bOut=cOut=dOut=0.
REQ-033 Rounding and sign: a=0x0001 sign 1, e=0x0080, others 0 -> aOut=0x0001, aOut_sign=1; with e=0x007F -> aOut=0x0000, aOut_sign=0.
REQ-034 Busy/back-to-back: pulse start again at T0+3 -> ignored; hold start high -> second capture at T0+10 and done pulses at T0+9 and T0+19.
REQ-035 Reset mid-op: assert rst_n=0 at T0+4 -> outputs 0, ready=1 immediately, no done; a fresh start after release completes normally.

Source files
------------

// File: rtl/mat2_sm_mul_if.sv
`default_nettype none
// ============================================================================
// Module   : mat2_sm_mul_if
// Brief    : Request/result bundle for the 2x2 sign-magnitude matrix multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mat2_sm_mul_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] aIn, bIn, cIn, dIn;
  logic             aIn_sign, bIn_sign, cIn_sign, dIn_sign;
  logic [WIDTH-1:0] eIn, fIn, gIn, hIn;
  logic             eIn_sign, fIn_sign, gIn_sign, hIn_sign;
  logic [WIDTH-1:0] aOut, bOut, cOut, dOut;
  logic             aOut_sign, bOut_sign, cOut_sign, dOut_sign;
  logic             ovf;

  modport master (
    output start,
    output aIn, bIn, cIn, dIn, aIn_sign, bIn_sign, cIn_sign, dIn_sign,
    output eIn, fIn, gIn, hIn, eIn_sign, fIn_sign, gIn_sign, hIn_sign,
    input  ready, done,
    input  aOut, bOut, cOut, dOut, aOut_sign, bOut_sign, cOut_sign, dOut_sign,
    input  ovf
  );

  modport slave (
    input  start,
    input  aIn, bIn, cIn, dIn, aIn_sign, bIn_sign, cIn_sign, dIn_sign,
    input  eIn, fIn, gIn, hIn, eIn_sign, fIn_sign, gIn_sign, hIn_sign,
    output ready, done,
    output aOut, bOut, cOut, dOut, aOut_sign, bOut_sign, cOut_sign, dOut_sign,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/mat2_sm_mul.sv
`default_nettype none
// ============================================================================
// Module   : mat2_sm_mul
// Brief    : 2x2 sign-magnitude fixed-point matrix multiply, one shared
//            multiplier, eight products sequenced over eight cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mat2_sm_mul #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mat2_sm_mul_if.slave  bus
);

  localparam int                   c_acc_w = 2*WIDTH + 2;
  localparam logic [c_acc_w:0]     c_half  = (c_acc_w+1)'(1) << (FRAC-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [2:0]                 r_k;
  logic [WIDTH-1:0]           r_xm [4];
  logic [3:0]                 r_xs;
  logic [WIDTH-1:0]           r_ym [4];
  logic [3:0]                 r_ys;
  logic signed [c_acc_w-1:0]  r_acc [4];
  logic [WIDTH-1:0]           r_out [4];
  logic [3:0]                 r_out_s;
  logic                       r_ovf;
  logic                       r_done;

  logic [WIDTH-1:0]           w_in_xm [4];
  logic [3:0]                 w_in_xs;
  logic [WIDTH-1:0]           w_in_ym [4];
  logic [3:0]                 w_in_ys;

  assign w_in_xm[0] = bus.aIn;
  assign w_in_xm[1] = bus.bIn;
  assign w_in_xm[2] = bus.cIn;
  assign w_in_xm[3] = bus.dIn;
  assign w_in_xs    = {bus.dIn_sign, bus.cIn_sign, bus.bIn_sign, bus.aIn_sign};
  assign w_in_ym[0] = bus.eIn;
  assign w_in_ym[1] = bus.fIn;
  assign w_in_ym[2] = bus.gIn;
  assign w_in_ym[3] = bus.hIn;
  assign w_in_ys    = {bus.hIn_sign, bus.gIn_sign, bus.fIn_sign, bus.eIn_sign};

  // Step k walks a*e, b*g, a*f, b*h, c*e, d*g, c*f, d*h; element index is k[2:1].
  logic [1:0]                 w_xi;
  logic [1:0]                 w_yi;
  logic [1:0]                 w_ei;
  logic [2*WIDTH-1:0]         w_prod;
  logic                       w_neg;
  logic signed [c_acc_w-1:0]  w_prod_ext;
  logic signed [c_acc_w-1:0]  w_term;

  assign w_xi       = {r_k[2], r_k[0]};
  assign w_yi       = {r_k[0], r_k[1]};
  assign w_ei       = r_k[2:1];
  assign w_prod     = r_xm[w_xi] * r_ym[w_yi];
  assign w_neg      = r_xs[w_xi] ^ r_ys[w_yi];
  assign w_prod_ext = $signed({2'b00, w_prod});
  assign w_term     = w_neg ? -w_prod_ext : w_prod_ext;

  logic [WIDTH-1:0]           w_res   [4];
  logic [3:0]                 w_res_s;
  logic [3:0]                 w_sat;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elem
      logic [c_acc_w-1:0] w_mag;
      logic [c_acc_w:0]   w_sum;
      logic [c_acc_w:0]   w_rnd;

      assign w_mag       = r_acc[gi][c_acc_w-1] ? c_acc_w'(-r_acc[gi]) : c_acc_w'(r_acc[gi]);
      assign w_sum       = {1'b0, w_mag} + c_half;
      assign w_rnd       = w_sum >> FRAC;
      assign w_sat[gi]   = |w_rnd[c_acc_w:WIDTH];
      assign w_res[gi]   = w_sat[gi] ? {WIDTH{1'b1}} : w_rnd[WIDTH-1:0];
      // A magnitude that rounds to zero never carries a sign.
      assign w_res_s[gi] = r_acc[gi][c_acc_w-1] & (|w_res[gi]);
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ACCUM;
      ACCUM:   if (r_k == 3'd7) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= 3'd0;
      r_xs    <= 4'd0;
      r_ys    <= 4'd0;
      r_out_s <= 4'd0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_xm[i]  <= '0;
        r_ym[i]  <= '0;
        r_acc[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_k  <= 3'd0;
            r_xs <= w_in_xs;
            r_ys <= w_in_ys;
            for (int i = 0; i < 4; i++) begin
              r_xm[i]  <= w_in_xm[i];
              r_ym[i]  <= w_in_ym[i];
              r_acc[i] <= '0;
            end
          end
        end
        ACCUM: begin
          r_acc[w_ei] <= r_acc[w_ei] + w_term;
          r_k         <= r_k + 3'd1;
        end
        FINISH: begin
          r_out_s <= w_res_s;
          r_ovf   <= |w_sat;
          r_done  <= 1'b1;
          for (int i = 0; i < 4; i++) r_out[i] <= w_res[i];
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (r_state == IDLE);
  assign bus.done      = r_done;
  assign bus.ovf       = r_ovf;
  assign bus.aOut      = r_out[0];
  assign bus.bOut      = r_out[1];
  assign bus.cOut      = r_out[2];
  assign bus.dOut      = r_out[3];
  assign bus.aOut_sign = r_out_s[0];
  assign bus.bOut_sign = r_out_s[1];
  assign bus.cOut_sign = r_out_s[2];
  assign bus.dOut_sign = r_out_s[3];

endmodule
`default_nettype wire

// File: tb/tb_mat2_sm_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat2_sm_mul
// Brief    : Directed self-checking bench for mat2_sm_mul.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat2_sm_mul;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mat2_sm_mul_if #(.WIDTH(16)) bus ();

  mat2_sm_mul #(.WIDTH(16), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // s = {a,b,c,d,e,f,g,h} signs
  task automatic set_ops(input logic [15:0] a, b, c, d, e, f, g, h, input logic [7:0] s);
    bus.aIn = a; bus.bIn = b; bus.cIn = c; bus.dIn = d;
    bus.eIn = e; bus.fIn = f; bus.gIn = g; bus.hIn = h;
    {bus.aIn_sign, bus.bIn_sign, bus.cIn_sign, bus.dIn_sign,
     bus.eIn_sign, bus.fIn_sign, bus.gIn_sign, bus.hIn_sign} = s;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ea, eb, ec, ed,
                         input logic [3:0] es, input logic eovf);
    chk({tag, ".aOut"}, bus.aOut, ea);
    chk({tag, ".bOut"}, bus.bOut, eb);
    chk({tag, ".cOut"}, bus.cOut, ec);
    chk({tag, ".dOut"}, bus.dOut, ed);
    chk({tag, ".signs"}, {bus.aOut_sign, bus.bOut_sign, bus.cOut_sign, bus.dOut_sign}, es);
    chk({tag, ".ovf"}, bus.ovf, eovf);
  endtask

  // Caller raises start at a negedge; capture happens on the following posedge.
  task automatic run_op(input string tag, input logic [15:0] ea, eb, ec, ed,
                        input logic [3:0] es, input logic eovf);
    int busy_bad;
    busy_bad = 0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.ready !== 1'b0 || bus.done !== 1'b0) busy_bad++;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.done !== 1'b0) busy_bad++;
    end
    chk({tag, ".busy_cycles"}, busy_bad, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done"}, bus.done, 1'b1);
    chk({tag, ".ready"}, bus.ready, 1'b1);
    chk_out(tag, ea, eb, ec, ed, es, eovf);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_clr"}, bus.done, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready", bus.ready, 1'b1);
    chk("rst.done", bus.done, 1'b0);
    chk_out("rst", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Identity-like product
    @(negedge clk);
    set_ops(16'h0200, 16'h0200, 16'h0100, 16'h0000,
            16'h0000, 16'h0100, 16'h0080, 16'h0100, 8'b0000_0001);
    bus.start = 1'b1;
    run_op("ident", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 4'b0000, 1'b0);

    // Mixed signs: [1.5 -2; 0.25 3] * [-1 0.5; 2 -0.75] = [-5.5 2.25; 5.75 -2.125]
    @(negedge clk);
    set_ops(16'h0180, 16'h0200, 16'h0040, 16'h0300,
            16'h0100, 16'h0080, 16'h0200, 16'h00C0, 8'b0100_1001);
    bus.start = 1'b1;
    run_op("mixed", 16'h0580, 16'h0240, 16'h05C0, 16'h0220, 4'b1001, 1'b0);

    // Saturation
    @(negedge clk);
    set_ops(16'h7F00, 16'h7F00, 16'h0000, 16'h0000,
            16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 8'h00);
    bus.start = 1'b1;
    run_op("sat", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b1);

    // Reset mid-operation after T0+4
    @(negedge clk);
    set_ops(16'h0180, 16'h0200, 16'h0040, 16'h0300,
            16'h0100, 16'h0080, 16'h0200, 16'h00C0, 8'b0100_1001);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", bus.ready, 1'b1);
    chk("midrst.done", bus.done, 1'b0);
    chk_out("midrst", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst.no_done", bus.done, 1'b0);

    // Rounding: -1/256 * 0.5 rounds away from zero to -1 LSB
    rst_n = 1'b1;
    set_ops(16'h0001, 16'h0000, 16'h0000, 16'h0000,
            16'h0080, 16'h0000, 16'h0000, 16'h0000, 8'b1000_0000);
    bus.start = 1'b1;
    run_op("rnd_half", 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 1'b0);

    // Just below half rounds to zero with no negative zero; -0 operand on b
    @(negedge clk);
    set_ops(16'h0001, 16'h0000, 16'h0000, 16'h0000,
            16'h007F, 16'h0000, 16'h0000, 16'h0000, 8'b1100_0000);
    bus.start = 1'b1;
    run_op("rnd_below", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b0);

    // Back-to-back with start held high and inputs changed after capture
    @(negedge clk);
    set_ops(16'h0200, 16'h0200, 16'h0100, 16'h0000,
            16'h0000, 16'h0100, 16'h0080, 16'h0100, 8'b0000_0001);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_ops(16'h0180, 16'h0200, 16'h0040, 16'h0300,
            16'h0100, 16'h0080, 16'h0200, 16'h00C0, 8'b0100_1001);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("b2b.done_early", bus.done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.done1", bus.done, 1'b1);
    chk_out("b2b.first", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.recapture_ready", bus.ready, 1'b0);
    chk("b2b.done1_clr", bus.done, 1'b0);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("b2b.done2_early", bus.done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.done2", bus.done, 1'b1);
    chk_out("b2b.second", 16'h0580, 16'h0240, 16'h05C0, 16'h0220, 4'b1001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
